// File: rtl/skew_monitor.sv
// rtl/skew_monitor.sv - rising-edge skew measurement between two asynchronous square waves
module skew_monitor #(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sig_a,
    input  logic             sig_b,
    output logic [CNT_W-1:0] skew,
    output logic             b_lags,
    output logic             skew_valid,
    output logic             timeout,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, ARMED, CNT_B, CNT_A} state_t;

    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] sync_a, sync_b;
    logic                   hist_a, hist_b;
    logic                   rise_a, rise_b;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic [CNT_W-1:0]       meas_val;
    logic                   meas_go, meas_lag, expire;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_a <= '0;
            sync_b <= '0;
            hist_a <= 1'b0;
            hist_b <= 1'b0;
        end else begin
            sync_a <= {sync_a[SYNC_STAGES-2:0], sig_a};
            sync_b <= {sync_b[SYNC_STAGES-2:0], sig_b};
            hist_a <= sync_a[SYNC_STAGES-1];
            hist_b <= sync_b[SYNC_STAGES-1];
        end
    end

    assign rise_a = sync_a[SYNC_STAGES-1] & ~hist_a;
    assign rise_b = sync_b[SYNC_STAGES-1] & ~hist_b;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:  state_nxt = ARMED;
                ARMED: begin
                    if (rise_a && !rise_b)      state_nxt = CNT_B;
                    else if (rise_b && !rise_a) state_nxt = CNT_A;
                end
                CNT_B: begin
                    if (rise_b)             state_nxt = ARMED;
                    else if (!rise_a && cnt == TO_VAL) state_nxt = ARMED;
                end
                CNT_A: begin
                    if (rise_a)             state_nxt = ARMED;
                    else if (!rise_b && cnt == TO_VAL) state_nxt = ARMED;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // A completing edge wins over a restart edge and over the timeout check.
    always_comb begin
        cnt_nxt  = '0;
        meas_go  = 1'b0;
        meas_val = cnt;
        meas_lag = 1'b0;
        expire   = 1'b0;
        busy     = (state == CNT_B) || (state == CNT_A);
        if (en) begin
            case (state)
                ARMED: begin
                    if (rise_a && rise_b) begin
                        meas_go  = 1'b1;
                        meas_val = '0;
                    end else if (rise_a || rise_b) begin
                        cnt_nxt = CNT_W'(1);
                    end
                end
                CNT_B: begin
                    if (rise_b) begin
                        meas_go  = 1'b1;
                        meas_lag = 1'b1;
                    end else if (rise_a) begin
                        cnt_nxt = CNT_W'(1);
                    end else if (cnt == TO_VAL) begin
                        expire = 1'b1;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                CNT_A: begin
                    if (rise_a) begin
                        meas_go = 1'b1;
                    end else if (rise_b) begin
                        cnt_nxt = CNT_W'(1);
                    end else if (cnt == TO_VAL) begin
                        expire = 1'b1;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                default: cnt_nxt = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= '0;
            skew       <= '0;
            b_lags     <= 1'b0;
            skew_valid <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            skew_valid <= meas_go;
            timeout    <= expire;
            if (meas_go) begin
                skew   <= meas_val;
                b_lags <= meas_lag;
            end
        end
    end

endmodule

// File: tb/tb_skew_monitor.sv
// tb/tb_skew_monitor.sv - directed bench for skew_monitor with an event-level reference model
module tb_skew_monitor;

    localparam int S  = 2;
    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst_n, en, sig_a, sig_b;
    logic [7:0] skew;
    logic       b_lags, skew_valid, timeout, busy;

    int checks = 0;
    int errors = 0;

    skew_monitor #(.CNT_W(8), .SYNC_STAGES(S), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .sig_a(sig_a), .sig_b(sig_b),
        .skew(skew), .b_lags(b_lags), .skew_valid(skew_valid),
        .timeout(timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Reference: input samples delayed by the synchronizer depth, then
    // measurements as timestamps (edge index of the first rise).
    bit         ha[0:S], hb[0:S];
    int         mn = 0;
    bit         m_armed = 0;
    int         m_side = 0;
    int         m_start = 0;
    logic [7:0] m_skew = '0;
    bit         m_lag = 0, m_valid = 0, m_to = 0;

    always @(posedge clk) begin
        bit ra, rb;
        mn++;
        m_valid = 0;
        m_to    = 0;
        if (!rst_n) begin
            for (int i = 0; i <= S; i++) begin ha[i] = 0; hb[i] = 0; end
            m_armed = 0; m_side = 0; m_skew = '0; m_lag = 0;
        end else begin
            ra = ha[S-1] && !ha[S];
            rb = hb[S-1] && !hb[S];
            for (int i = S; i > 0; i--) begin ha[i] = ha[i-1]; hb[i] = hb[i-1]; end
            ha[0] = sig_a;
            hb[0] = sig_b;
            if (!en) begin
                m_armed = 0; m_side = 0;
            end else if (!m_armed) begin
                m_armed = 1;
            end else if (m_side == 0) begin
                if (ra && rb) begin m_valid = 1; m_skew = '0; m_lag = 0; end
                else if (ra) begin m_side = 1; m_start = mn; end
                else if (rb) begin m_side = 2; m_start = mn; end
            end else begin
                bit done, again;
                done  = (m_side == 1) ? rb : ra;
                again = (m_side == 1) ? ra : rb;
                if (done) begin
                    m_valid = 1; m_skew = 8'(mn - m_start); m_lag = (m_side == 1); m_side = 0;
                end else if (again) begin
                    m_start = mn;
                end else if (mn - m_start == TO) begin
                    m_to = 1; m_side = 0;
                end
            end
        end
    end

    bit mon_on = 0;
    int vcnt = 0, tcnt = 0;
    bit busy_seen = 0;

    always @(negedge clk) begin
        if (mon_on) begin
            chk("model_skew", int'(skew), int'(m_skew));
            chk("model_b_lags", int'(b_lags), int'(m_lag));
            chk("model_skew_valid", int'(skew_valid), int'(m_valid));
            chk("model_timeout", int'(timeout), int'(m_to));
            chk("model_busy", int'(busy), int'(m_side != 0));
        end
        if (skew_valid) vcnt++;
        if (timeout)    tcnt++;
        if (busy)       busy_seen = 1;
    end

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_counts();
        vcnt = 0; tcnt = 0; busy_seen = 0;
    endtask

    task automatic run_wave(input int per, input int da, input int db, input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            step();
            sig_a = (c >= da) && (((c - da) % per) < per / 2);
            sig_b = (c >= db) && (((c - db) % per) < per / 2);
        end
        step();
        sig_a = 0;
        sig_b = 0;
        step(10);
    endtask

    initial begin
        int first_busy, first_to;
        rst_n = 0; en = 0; sig_a = 0; sig_b = 0;
        step(3);
        mon_on = 1;
        @(negedge clk);
        chk("reset_skew", int'(skew), 0);
        chk("reset_b_lags", int'(b_lags), 0);
        chk("reset_valid", int'(skew_valid), 0);
        chk("reset_timeout", int'(timeout), 0);
        chk("reset_busy", int'(busy), 0);
        step();
        rst_n = 1; en = 1;
        step(4);

        // Timeout: A toggles, B never rises.
        clear_counts();
        first_busy = 0; first_to = 0;
        for (int p = 0; p < 2; p++) begin
            step();
            sig_a = 1;
            for (int k = 1; k <= 40; k++) begin
                @(negedge clk);
                if (p == 0 && busy && first_busy == 0) first_busy = k;
                if (p == 0 && timeout && first_to == 0) first_to = k;
                if (k == 20) sig_a = 0;
            end
        end
        chk("timeout_cycle", first_to - first_busy + 1, 17);
        chk("timeout_count", tcnt, 2);
        chk("timeout_no_valid", vcnt, 0);
        chk("timeout_skew", int'(skew), 0);

        // Aligned edges.
        clear_counts();
        run_wave(20, 0, 0, 100);
        chk("aligned_count", vcnt, 5);
        chk("aligned_skew", int'(skew), 0);
        chk("aligned_b_lags", int'(b_lags), 0);
        chk("aligned_busy", int'(busy_seen), 0);

        // A lags B by 3.
        clear_counts();
        run_wave(20, 3, 0, 100);
        chk("alag_count", vcnt, 5);
        chk("alag_skew", int'(skew), 3);
        chk("alag_b_lags", int'(b_lags), 0);

        // B lags A by 3.
        clear_counts();
        run_wave(20, 0, 3, 100);
        chk("blag_count", vcnt, 5);
        chk("blag_skew", int'(skew), 3);
        chk("blag_b_lags", int'(b_lags), 1);

        // Reset two cycles into CNT_B.
        clear_counts();
        step();
        sig_a = 1;
        step(4);
        chk("rstabort_busy_before", int'(busy), 1);
        rst_n = 0; sig_a = 0;
        step();
        rst_n = 1;
        @(negedge clk);
        chk("rstabort_skew", int'(skew), 0);
        chk("rstabort_b_lags", int'(b_lags), 0);
        chk("rstabort_busy", int'(busy), 0);
        step(30);
        chk("rstabort_no_valid", vcnt, 0);
        chk("rstabort_no_timeout", tcnt, 0);

        // A re-rises 5 cycles after its first edge, B 2 cycles after that.
        clear_counts();
        step();  sig_a = 1;
        step(2); sig_a = 0;
        step(3); sig_a = 1;
        step(2); sig_b = 1;
        step(10);
        chk("rerise_count", vcnt, 1);
        chk("rerise_skew", int'(skew), 2);
        chk("rerise_b_lags", int'(b_lags), 1);
        sig_a = 0; sig_b = 0;
        step(6);

        // Enable dropped mid-count in the same cycle B's edge completes.
        clear_counts();
        step();  sig_a = 1;
        step(2); sig_b = 1;
        step(2);
        chk("enabort_busy_before", int'(busy), 1);
        en = 0;
        step();
        en = 1;
        @(negedge clk);
        chk("enabort_busy", int'(busy), 0);
        chk("enabort_skew", int'(skew), 2);
        chk("enabort_b_lags", int'(b_lags), 1);
        step(30);
        chk("enabort_no_valid", vcnt, 0);
        chk("enabort_no_timeout", tcnt, 0);
        sig_a = 0; sig_b = 0;
        step(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/skew_monitor.md
# skew_monitor

Single-clock skew monitor that measures the rising-edge offset between two periodic square waves, such as a launch clock and a delayed copy of it. It reports the offset as a whole number of `clk` cycles, plus which input lags the other. It is the receive-side counterpart of the skew generator: the generator produces the skewed pair, and this block recovers the skew inside one synchronous domain. Each completed measurement produces a one-cycle `skew_valid` pulse. If the second edge never arrives, the block produces a `timeout` pulse instead.

## Interface
- `CNT_W`, default 8: width of the skew counter and of the `skew` output.
- `SYNC_STAGES`, default 2: number of synchronizer flops on each of `sig_a` and `sig_b`. Must be at least 2.
- `TIMEOUT`, default 255: maximum count before a measurement is abandoned. Range is 1 to 2^CNT_W−1.
- `clk`  input  1: single system clock. All logic is on its rising edge.
- `rst_n`  input  1: reset, synchronous and active-low.
- `en`  input  1: measurement enable.
- `sig_a`  input  1: reference waveform. Asynchronous to `clk`.
- `sig_b`  input  1: skewed waveform. Asynchronous to `clk`.
- `skew`  output  CNT_W: last measured offset, in `clk` cycles.
- `b_lags`  output  1: 1 means `sig_b` rose after `sig_a`; 0 means `sig_a` lagged, or both rose together.
- `skew_valid`  output  1: one-cycle pulse when `skew` and `b_lags` update.
- `timeout`  output  1: one-cycle pulse when a measurement is abandoned.
- `busy`  output  1: high while a measurement is in progress.

## Operation
- Synchronizers:
  - Each input passes through `SYNC_STAGES` flops, followed by one edge-history flop.
  - `rise_a` and `rise_b` are single-cycle pulses: synchronized value = 1 and history value = 0.
- FSM states are IDLE, ARMED, CNT_B and CNT_A. `busy` = (state is CNT_B or CNT_A).
- IDLE:
  - Counter held at 0.
  - When `en`=1, go to ARMED.
- ARMED:
  - `rise_a` and `rise_b` together: `skew`←0, `b_lags`←0, pulse `skew_valid`, stay in ARMED.
  - `rise_a` only: counter←1, go to CNT_B.
  - `rise_b` only: counter←1, go to CNT_A.
- CNT_B (waiting for B):
  - `rise_b`: `skew`←counter, `b_lags`←1, pulse `skew_valid`, go to ARMED. If `rise_a` is also high in the same cycle, B still completes the measurement and the new A edge is ignored.
  - `rise_a` without `rise_b` (A rose twice before B): counter←1, stay in CNT_B.
  - Neither edge, and counter = TIMEOUT: pulse `timeout`, counter←0, go to ARMED. `skew` and `b_lags` are unchanged.
  - Neither edge otherwise: counter←counter+1.
- CNT_A mirrors CNT_B with A and B swapped, and loads `b_lags`←0.
- `en`=0 in any state forces IDLE on the next edge:
  - Counter is cleared.
  - `skew` and `b_lags` are held.
  - No pulse is produced, even if an edge completes in that cycle.
- Arithmetic:
  - The counter is unsigned CNT_W bits and never wraps, because TIMEOUT ≤ 2^CNT_W−1 and the timeout check takes priority over the increment.
  - Measured `skew` is in the range 0 to TIMEOUT.
- Reset values (`rst_n`=0 at a clock edge):
  - State = IDLE.
  - All synchronizer and history flops = 0.
  - Counter = 0, `skew` = 0, `b_lags` = 0, `skew_valid` = 0, `timeout` = 0, `busy` = 0.
  - Reset mid-measurement aborts it without any pulse.

## Timing
- Input edge to `rise_*` pulse: `SYNC_STAGES`+1 cycles. With the default this is 3 cycles.
- Both inputs see identical latency, so the reported `skew` is the true offset rounded to whole `clk` cycles, with ±1 cycle uncertainty from asynchronous sampling.
- `skew`, `b_lags`, `skew_valid` and `timeout` are registered. They become visible in the cycle after the FSM samples the completing or expiring condition.
- `skew_valid` and `timeout` are never both high. Each lasts exactly one cycle.
- `timeout` asserts TIMEOUT+1 cycles after the clock edge that loaded counter←1.
- After any pulse the FSM is in ARMED, so back-to-back periods are measured continuously with no dead cycle.

## Test plan
- **B lags A.** Stimulus: `sig_a` period 20 cycles, `sig_b` = `sig_a` delayed by 3 cycles, `en`=1. Required: one `skew_valid` per period with `skew`=3 and `b_lags`=1.
- **A lags B.** Stimulus: the same waveforms with the delay applied to `sig_a` instead. Required: `skew`=3 and `b_lags`=0 each period.
- **Edges aligned.** Stimulus: `sig_a` = `sig_b`. Required: `skew`=0, `b_lags`=0, and `busy` never asserts.
- **Timeout.** Stimulus: TIMEOUT=16, `sig_a` toggling, `sig_b` held at 0. Required: a `timeout` pulse 17 cycles after each A-start. `skew_valid` never asserts and `skew` keeps its reset value 0.
- **Abort by reset or enable.** Stimulus: `rst_n` driven low for one edge 2 cycles into CNT_B. Required: all outputs return to 0 and no pulse appears. Repeat with `en` dropped mid-count instead. Required: IDLE on the next cycle, `skew` holds its previous value, and no pulse appears.
- **A re-rises before B.** Stimulus: two `rise_a` pulses 5 cycles apart, then `rise_b` 2 cycles after the second. Required: `skew`=2, `b_lags`=1.
